// File: rtl/seq_match_pkg.sv
// Shared types and default sizing for the serial pattern scanner.
// Holds the controller state encoding, default parameter values and
// helper functions that derive port widths from those parameters.
package seq_match_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned PAT_MAX_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width needed to hold a pattern length of 0..pat_max.
  function automatic int unsigned len_width(input int unsigned pat_max);
    return $clog2(pat_max + 1);
  endfunction

  // Width needed to index bits 0..data_w-1 of the scanned word.
  function automatic int unsigned idx_width(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pat_window_match.sv
// Serial window shift register with a length-masked pattern compare.
// Ports:
//   clk        clock
//   serial_bit next stream bit, shifted into the LSB when shift=1
//   shift      advance the window by one bit
//   clear      zero the window (has priority over shift)
//   pattern    right-aligned pattern to compare against
//   pat_len    number of low bits that take part in the compare (0 = never)
//   match_c    combinational: the window after this shift matches
module pat_window_match
  import seq_match_pkg::*;
#(
  parameter  int unsigned PAT_MAX = PAT_MAX_DEF,
  localparam int unsigned LEN_W   = len_width(PAT_MAX)
) (
  input  logic               clk,
  input  logic               serial_bit,
  input  logic               shift,
  input  logic               clear,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  output logic               match_c
);

  logic [PAT_MAX-1:0] window;
  logic [PAT_MAX-1:0] window_nxt;
  logic [PAT_MAX-1:0] mask;

  // Compare is made against the window as it will be after this bit,
  // so a match is known in the same cycle the bit is consumed.
  always_comb begin
    window_nxt = (window << 1) | PAT_MAX'(serial_bit);
    mask       = '0;
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      mask[i] = (32'(pat_len) > i);
    end
    match_c = (pat_len != '0) && ((window_nxt & mask) == (pattern & mask));
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      window <= '0;
    end else if (shift) begin
      window <= window_nxt;
    end
  end

endmodule

// File: rtl/seq_match_scanner.sv
// Scans a latched word MSB-first through a programmable serial pattern
// matcher and summarises the results (count, first position, strobes).
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        request a scan (accepted only in IDLE)
//   data_in      word to scan, latched on accepted start
//   pattern      right-aligned pattern, latched on accepted start
//   pat_len      pattern length, clamped to PAT_MAX, latched on start
//   busy         high while bits are being consumed
//   done         one-cycle pulse after the last bit
//   hit          one-cycle strobe per match
//   found        at least one match in the current/last scan
//   match_count  saturating match count
//   first_idx    stream index (0 = MSB) of the last bit of the first match
module seq_match_scanner
  import seq_match_pkg::*;
#(
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned PAT_MAX = PAT_MAX_DEF,
  parameter  int unsigned CNT_W   = CNT_W_DEF,
  localparam int unsigned LEN_W   = len_width(PAT_MAX),
  localparam int unsigned IDX_W   = idx_width(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic               found,
  output logic [CNT_W-1:0]   match_count,
  output logic [IDX_W-1:0]   first_idx
);

  localparam int unsigned CMP_W = max_u(IDX_W + 1, LEN_W);

  state_t             state;
  logic [DATA_W-1:0]  data_q;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   bit_idx;
  logic [LEN_W-1:0]   len_clamp;
  logic               accept;
  logic               win_match_c;
  logic               match_ok;

  assign accept    = (state == ST_IDLE) && start;
  assign len_clamp = (pat_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : pat_len;

  // Window is cleared on reset and on every accepted start so that a new
  // scan never sees bits left over from the previous word.
  pat_window_match #(
    .PAT_MAX (PAT_MAX)
  ) u_window (
    .clk        (clk),
    .serial_bit (data_q[DATA_W-1]),
    .shift      (state == ST_SHIFT),
    .clear      (rst || accept),
    .pattern    (pat_q),
    .pat_len    (len_q),
    .match_c    (win_match_c)
  );

  // A match only counts once at least pat_len bits have entered the window.
  assign match_ok = win_match_c &&
                    ((CMP_W'(bit_idx) + CMP_W'(1)) >= CMP_W'(len_q));

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      data_q      <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      bit_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      found       <= 1'b0;
      match_count <= '0;
      first_idx   <= '0;
    end else begin
      hit  <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            data_q      <= data_in;
            pat_q       <= pattern;
            len_q       <= len_clamp;
            bit_idx     <= '0;
            found       <= 1'b0;
            match_count <= '0;
            first_idx   <= '0;
            busy        <= 1'b1;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_q  <= data_q << 1;
          bit_idx <= bit_idx + IDX_W'(1);
          if (match_ok) begin
            hit <= 1'b1;
            if (match_count != {CNT_W{1'b1}}) begin
              match_count <= match_count + CNT_W'(1);
            end
            if (!found) begin
              found     <= 1'b1;
              first_idx <= bit_idx;
            end
          end
          if (bit_idx == IDX_W'(DATA_W - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_scanner.sv
// Directed bench for seq_match_scanner: default instance plus a CNT_W=4
// instance driven by the same stimulus to exercise counter saturation.
module tb_seq_match_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic [7:0]  pattern;
  logic [3:0]  pat_len;

  logic        busy, done, hit, found;
  logic [5:0]  match_count;
  logic [4:0]  first_idx;

  logic        busy4, done4, hit4, found4;
  logic [3:0]  match_count4;
  logic [4:0]  first_idx4;

  int          n_chk  = 0;
  int          n_pass = 0;

  logic [63:0] hit_mask;
  int          done_cyc;
  int          done_cnt;
  int          busy_cnt;
  int          bad_after_rst;

  always #5 clk = ~clk;

  seq_match_scanner #(.DATA_W(32), .PAT_MAX(8), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .busy        (busy),
    .done        (done),
    .hit         (hit),
    .found       (found),
    .match_count (match_count),
    .first_idx   (first_idx)
  );

  seq_match_scanner #(.DATA_W(32), .PAT_MAX(8), .CNT_W(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .busy        (busy4),
    .done        (done4),
    .hit         (hit4),
    .found       (found4),
    .match_count (match_count4),
    .first_idx   (first_idx4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge (cycle 0). Runs cycles 1..40 sampling at negedges.
  // ev_kind: 0 none, 1 stray start in cycle ev_cyc, 2 rst in cycle ev_cyc.
  task automatic do_scan(input logic [31:0] d, input logic [7:0] p, input logic [3:0] l,
                         input int ev_cyc, input int ev_kind);
    hit_mask      = '0;
    done_cyc      = -1;
    done_cnt      = 0;
    busy_cnt      = 0;
    bad_after_rst = 0;
    data_in = d;
    pattern = p;
    pat_len = l;
    start   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (hit) hit_mask[c] = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) busy_cnt++;
      if (ev_kind == 2 && c > ev_cyc &&
          (busy || done || hit || found || match_count != '0 || first_idx != '0))
        bad_after_rst++;
      start = 1'b0;
      rst   = 1'b0;
      if (c == ev_cyc) begin
        if (ev_kind == 1) begin
          start   = 1'b1;
          data_in = 32'h0;
          pattern = 8'h01;
          pat_len = 4'd1;
        end else if (ev_kind == 2) begin
          rst = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    pattern = '0;
    pat_len = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_hit",   64'(hit), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_count", 64'(match_count), 64'd0);
    check("rst_first", 64'(first_idx), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Periodic 1100 pattern: matches end on bits 3, 11, 19, 27.
    do_scan(32'hC3C3C3C3, 8'b1100, 4'd4, 0, 0);
    check("c3_hits",  hit_mask, (64'd1 << 5) | (64'd1 << 13) | (64'd1 << 21) | (64'd1 << 29));
    check("c3_done_cyc", 64'(done_cyc), 64'd33);
    check("c3_done_cnt", 64'(done_cnt), 64'd1);
    check("c3_busy_cnt", 64'(busy_cnt), 64'd32);
    check("c3_count", 64'(match_count), 64'd4);
    check("c3_first", 64'(first_idx), 64'd3);
    check("c3_found", 64'(found), 64'd1);
    check("c3_count4", 64'(match_count4), 64'd4);

    // All ones, overlapping 11: 31 matches, saturating at 15 for CNT_W=4.
    do_scan(32'hFFFFFFFF, 8'b11, 4'd2, 0, 0);
    check("ff_count", 64'(match_count), 64'd31);
    check("ff_first", 64'(first_idx), 64'd1);
    check("ff_found", 64'(found), 64'd1);
    check("ff_count4_sat", 64'(match_count4), 64'd15);
    check("ff_found4", 64'(found4), 64'd1);

    // Match only on the last bit: hit lands in the DONE cycle.
    do_scan(32'h0000000C, 8'b1100, 4'd4, 0, 0);
    check("last_hits", hit_mask, 64'd1 << 33);
    check("last_done_cyc", 64'(done_cyc), 64'd33);
    check("last_count", 64'(match_count), 64'd1);
    check("last_first", 64'(first_idx), 64'd31);

    // pat_len 0 never matches.
    do_scan(32'hC3C3C3C3, 8'b1, 4'd0, 0, 0);
    check("len0_hits", hit_mask, 64'd0);
    check("len0_done_cyc", 64'(done_cyc), 64'd33);
    check("len0_count", 64'(match_count), 64'd0);
    check("len0_found", 64'(found), 64'd0);
    check("len0_first", 64'(first_idx), 64'd0);

    // Data 0 with pattern 1.
    do_scan(32'h0, 8'b1, 4'd1, 0, 0);
    check("zero_done_cyc", 64'(done_cyc), 64'd33);
    check("zero_count", 64'(match_count), 64'd0);
    check("zero_found", 64'(found), 64'd0);

    // pat_len 15 clamps to 8: 0xFF byte matches at bits 7 and 23.
    do_scan(32'hFF00FF00, 8'hFF, 4'd15, 0, 0);
    check("clamp_count", 64'(match_count), 64'd2);
    check("clamp_first", 64'(first_idx), 64'd7);
    check("clamp_hits", hit_mask, (64'd1 << 9) | (64'd1 << 25));

    // Stray start in cycle 10 is ignored.
    do_scan(32'hC3C3C3C3, 8'b1100, 4'd4, 10, 1);
    check("stray_done_cyc", 64'(done_cyc), 64'd33);
    check("stray_done_cnt", 64'(done_cnt), 64'd1);
    check("stray_count", 64'(match_count), 64'd4);

    // Reset in cycle 10 aborts the scan without a done pulse.
    do_scan(32'hC3C3C3C3, 8'b1100, 4'd4, 10, 2);
    check("abort_done_cnt", 64'(done_cnt), 64'd0);
    check("abort_busy_cnt", 64'(busy_cnt), 64'd10);
    check("abort_outputs_zero", 64'(bad_after_rst), 64'd0);
    check("abort_hits", hit_mask, 64'd1 << 5);

    // Next scan after abort runs normally.
    do_scan(32'hC3C3C3C3, 8'b1100, 4'd4, 0, 0);
    check("after_done_cyc", 64'(done_cyc), 64'd33);
    check("after_count", 64'(match_count), 64'd4);
    check("after_first", 64'(first_idx), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_match_scanner.md
# seq_match_scanner

- Scans a latched DATA_W-bit word MSB-first through a programmable serial pattern matcher (1..PAT_MAX bits, overlapping matches).
- Reports match count, first-match position and per-match strobes with a start/done handshake.
- Sits in front of the serial sequence-detector datapath: it sequences the serialization, holds the pattern configuration and summarises results for the host.

## Interface
- DATA_W, 32, scanned word width; ≥ 2.
- PAT_MAX, 8, maximum pattern length in bits.
- CNT_W, 6, match counter width; counter saturates.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request scan; sampled only in IDLE.
- data_in  in  DATA_W  word to scan; latched on accepted start.
- pattern  in  PAT_MAX  pattern, right-aligned; bit pat_len-1 is the first serial bit; latched on accepted start.
- pat_len  in  $clog2(PAT_MAX+1)  pattern length; latched on accepted start.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse in DONE.
- hit  out  1  one-cycle strobe per match.
- found  out  1  at least one match in the last scan.
- match_count  out  CNT_W  matches in the current/last scan.
- first_idx  out  $clog2(DATA_W)  stream index (0 = MSB) of the last bit of the first match.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches data_in, pattern and pat_len (clamped to PAT_MAX if larger).
  - Same edge clears match_count, found, first_idx, hit and the window/bit counter; state goes to SHIFT.
- SHIFT:
  - Consumes one bit per cycle, MSB first.
  - Window (PAT_MAX bits) shifts left, new bit in the LSB.
  - Match when bits_consumed ≥ pat_len and the low pat_len bits of the updated window equal pattern[pat_len-1:0].
  - After DATA_W bits, state goes to DONE.
- On a match edge:
  - hit is registered high.
  - match_count increments, saturating at 2^CNT_W-1.
  - If found=0: found←1 and first_idx←current bit index.
- DONE: done=1 for one cycle, then IDLE.
- Results hold in IDLE until the next accepted start.
- pat_len=0: no match is ever flagged; the scan still runs full length; done asserts with count 0, found 0.
- start is ignored in SHIFT and DONE (no queueing).
- Overlapping matches are all counted (window is not flushed on a match).

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1..DATA_W: SHIFT; bit k is consumed in cycle k+1.
- A match on bit k gives hit=1 in cycle k+2; match_count/found/first_idx reflect it from cycle k+2.
- Cycle DATA_W+1: DONE, done=1; hit may be high here for a match on the last bit.
- Start-to-done latency is DATA_W+1 cycles. The earliest next start is sampled in cycle DATA_W+2.
- Reset values: busy, done, hit, found = 0; match_count = 0; first_idx = 0; state = IDLE.
- rst mid-scan: IDLE on the next edge, all outputs zero, no done pulse.
- rst has priority over start.

## Structure
- Package seq_match_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - default parameter constants;
  - widths derived with $clog2.
- One sub-module, pat_window_match:
  - window shift register plus masked compare;
  - inputs: bit, shift enable, clear, pattern, pat_len;
  - output: combinational match on the next window.
- The controller FSM, bit counter, saturating counter and result registers stay in the top.

## Test plan
- data 0xC3C3C3C3, pattern 0b1100, pat_len 4 → hit in cycles 5, 13, 21, 29; done at cycle 33; match_count 4, first_idx 3, found 1.
- data 0xFFFFFFFF, pattern 0b11, pat_len 2 → match_count 31, first_idx 1 (overlap).
- Same stimulus with CNT_W=4 → match_count saturates at 15, found 1.
- data 0x0000000C, pattern 0b1100, pat_len 4 → single hit in the DONE cycle (33); match_count 1, first_idx 31.
- pat_len 0 or data 0 with pattern 0b1 → done at cycle 33, match_count 0, found 0, first_idx 0.
- Two cases:
  - start pulsed in cycle 10 of a scan → ignored, done still at cycle 33;
  - rst in cycle 10 → busy 0 from cycle 11, no done pulse, outputs 0, next start accepted normally.
